// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data-memory port between the instruction-cache
// controller (I side) and the data-cache controller (D side).
//
// One side owns the port at a time. The owner's enable/write/address/data bundle
// is forwarded to memory combinationally, and memory `ready` is returned only to
// the owner. Ownership is held until the owner drops its enable. That cycle is
// followed by exactly one dead TURN cycle, then the next grant. On contention
// the 1-bit priority pointer picks the winner. On release the pointer moves to
// the side that did not own the port, so contending sides alternate.
//
// Optional build feature:
//   MEM_ARB_PERF_EN - adds 32-bit wrapping counters perf_I_grants, perf_D_grants
//                     and perf_conflict as extra output ports.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   I_enable, I_address  I side request bundle (read only)
//   I_ready              memory ready, only while I owns the port
//   D_enable, D_write,
//   D_address, D_wdata   D side request bundle
//   D_ready              memory ready, only while D owns the port
//   mem_enable, mem_write,
//   mem_address, mem_wdata  forwarded bundle to memory
//   ready                memory beat complete
//   owner                2'b00 none, 2'b01 I, 2'b10 D

module mem_arbiter #(
  parameter int unsigned data_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 I_enable,
  input  logic [data_size-1:0] I_address,
  output logic                 I_ready,
  input  logic                 D_enable,
  input  logic                 D_write,
  input  logic [data_size-1:0] D_address,
  input  logic [data_size-1:0] D_wdata,
  output logic                 D_ready,
  output logic                 mem_enable,
  output logic                 mem_write,
  output logic [data_size-1:0] mem_address,
  output logic [data_size-1:0] mem_wdata,
  input  logic                 ready,
  output logic [1:0]           owner
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_I_grants,
  output logic [31:0]          perf_D_grants,
  output logic [31:0]          perf_conflict
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StOwnI,
    StOwnD,
    StTurn
  } state_e;

  state_e     state_q, state_d;
  logic       prio_q, prio_d;  // 0 = I wins a tie, 1 = D wins a tie
  logic [1:0] beat_q, beat_d;  // beats completed in the current ownership

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      beat_q  <= beat_d;
    end
  end

  // Next state and outputs
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    beat_d      = beat_q;
    I_ready     = 1'b0;
    D_ready     = 1'b0;
    mem_enable  = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    owner       = 2'b00;

    unique case (state_q)
      StIdle, StTurn: begin
        // Memory ready is ignored here; nobody owns the port.
        if (state_q == StTurn) beat_d = 2'd0;
        if (I_enable && (!D_enable || !prio_q)) begin
          state_d = StOwnI;
        end else if (D_enable) begin
          state_d = StOwnD;
        end else begin
          state_d = StIdle;
        end
      end

      StOwnI: begin
        owner       = 2'b01;
        // Enable follows the owner so the release cycle drives no access.
        mem_enable  = I_enable;
        mem_address = I_address;
        I_ready     = ready;
        if (ready) beat_d = beat_q + 2'd1;
        if (!I_enable) begin
          state_d = StTurn;
          prio_d  = 1'b1;
        end
      end

      StOwnD: begin
        owner       = 2'b10;
        mem_enable  = D_enable;
        mem_write   = D_write;
        mem_address = D_address;
        mem_wdata   = D_wdata;
        D_ready     = ready;
        if (ready) beat_d = beat_q + 2'd1;
        if (!D_enable) begin
          state_d = StTurn;
          prio_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  logic conflict;

  // A request is contended when the other side owns the port, or when both
  // sides ask at once while the port is free.
  always_comb begin
    conflict = 1'b0;
    unique case (state_q)
      StOwnI:  conflict = D_enable;
      StOwnD:  conflict = I_enable;
      default: conflict = I_enable & D_enable;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_I_grants <= 32'd0;
      perf_D_grants <= 32'd0;
      perf_conflict <= 32'd0;
    end else begin
      if (state_d == StOwnI && state_q != StOwnI) perf_I_grants <= perf_I_grants + 32'd1;
      if (state_d == StOwnD && state_q != StOwnD) perf_D_grants <= perf_D_grants + 32'd1;
      if (conflict) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_enable;
  logic [31:0] I_address;
  logic        I_ready;
  logic        D_enable;
  logic        D_write;
  logic [31:0] D_address;
  logic [31:0] D_wdata;
  logic        D_ready;
  logic        mem_enable;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        ready;
  logic [1:0]  owner;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_I_grants;
  logic [31:0] perf_D_grants;
  logic [31:0] perf_conflict;
`endif

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.data_size(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .I_enable   (I_enable),
    .I_address  (I_address),
    .I_ready    (I_ready),
    .D_enable   (D_enable),
    .D_write    (D_write),
    .D_address  (D_address),
    .D_wdata    (D_wdata),
    .D_ready    (D_ready),
    .mem_enable (mem_enable),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .ready      (ready),
    .owner      (owner)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_I_grants(perf_I_grants),
    .perf_D_grants(perf_D_grants),
    .perf_conflict(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic chk_own(input string tag, input logic [1:0] exp);
    chk(tag, {30'b0, owner}, {30'b0, exp});
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic       ie_v  [12];
  logic       de_v  [12];
  logic [1:0] own_v [12];

  initial begin
    ie_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    de_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    own_v = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};

    rst = 1'b1; I_enable = 1'b0; I_address = '0; D_enable = 1'b0; D_write = 1'b0;
    D_address = '0; D_wdata = '0; ready = 1'b0;
    cyc();
    cyc();

    // Reset state; memory ready must not leak while idle.
    ready = 1'b1;
    settle();
    chk_own("reset_owner", 2'b00);
    chk1("reset_men", mem_enable, 1'b0);
    chk1("reset_iready", I_ready, 1'b0);
    chk1("reset_dready", D_ready, 1'b0);
    chk("reset_addr", mem_address, 32'h0);
    rst = 1'b0;
    ready = 1'b0;

    // Solo I refill of 4 beats.
    I_enable = 1'b1; I_address = 32'h100;
    settle();
    chk_own("solo_idle_owner", 2'b00);
    chk1("solo_idle_men", mem_enable, 1'b0);
    cyc();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_own("solo_owner", 2'b01);
      chk1("solo_men", mem_enable, 1'b1);
      chk1("solo_mwr", mem_write, 1'b0);
      chk("solo_addr", mem_address, 32'h100);
      chk1("solo_iready", I_ready, 1'b1);
      chk1("solo_dready", D_ready, 1'b0);
      cyc();
    end
    I_enable = 1'b0; ready = 1'b0;
    settle();
    chk1("solo_rel_men", mem_enable, 1'b0);
    chk_own("solo_rel_owner", 2'b01);
    cyc();
    settle();
    chk_own("solo_turn_owner", 2'b00);
    chk1("solo_turn_men", mem_enable, 1'b0);
    cyc();
    settle();
    chk_own("solo_idle2_owner", 2'b00);

    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Simultaneous request after reset: I first, then a D write after handover.
    I_enable = 1'b1; I_address = 32'h104;
    D_enable = 1'b1; D_write = 1'b1; D_address = 32'h200; D_wdata = 32'hDEADBEEF;
    settle();
    chk_own("sim_idle_owner", 2'b00);
    cyc();
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_own("sim_i_owner", 2'b01);
      chk("sim_i_addr", mem_address, 32'h104);
      chk1("sim_i_mwr", mem_write, 1'b0);
      chk1("sim_i_iready", I_ready, 1'b1);
      chk1("hold_dready", D_ready, 1'b0);
      cyc();
    end
    I_enable = 1'b0;
    settle();
    chk1("sim_rel_men", mem_enable, 1'b0);
    chk1("sim_rel_dready", D_ready, 1'b0);
    cyc();
    settle();
    chk_own("sim_turn_owner", 2'b00);
    chk1("sim_turn_men", mem_enable, 1'b0);
    chk1("sim_turn_dready", D_ready, 1'b0);
    chk1("sim_turn_iready", I_ready, 1'b0);
    cyc();
    settle();
    chk_own("sim_d_owner", 2'b10);
    chk1("sim_d_men", mem_enable, 1'b1);
    chk1("sim_d_mwr", mem_write, 1'b1);
    chk("sim_d_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sim_d_addr", mem_address, 32'h200);
    chk1("sim_d_dready", D_ready, 1'b1);
    chk1("sim_d_iready", I_ready, 1'b0);
    cyc();

    // Second D beat with reset asserted; I also requesting.
    I_enable = 1'b1; rst = 1'b1;
    settle();
    chk_own("mid_owner", 2'b10);
    chk1("mid_iready", I_ready, 1'b0);
    cyc();
    rst = 1'b0;
    settle();
    chk_own("rst_mid_owner", 2'b00);
    chk1("rst_mid_men", mem_enable, 1'b0);
    chk1("rst_mid_mwr", mem_write, 1'b0);
    chk("rst_mid_wdata", mem_wdata, 32'h0);
    chk("rst_mid_addr", mem_address, 32'h0);
    chk1("rst_mid_dready", D_ready, 1'b0);
    cyc();
    settle();
    // Pointer was pointing at D before reset; reset must return it to I.
    chk_own("rst_mid_prio", 2'b01);
    I_enable = 1'b0; D_enable = 1'b0; D_write = 1'b0; ready = 1'b0;
    cyc();
    cyc();

    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Alternation under contention (and perf counting scenario).
    I_address = 32'h300; D_address = 32'h400;
    for (int c = 0; c < 12; c++) begin
      I_enable = ie_v[c];
      D_enable = de_v[c];
      settle();
      chk_own("alt_owner", own_v[c]);
      cyc();
    end

`ifdef MEM_ARB_PERF_EN
    chk("perf_i", perf_I_grants, 32'd3);
    chk("perf_d", perf_D_grants, 32'd2);
    chk("perf_conf", perf_conflict, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
